// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - decode/execute pipeline register with load-use hazard detection and operand forwarding
// Optional feature macro: FORWARDING_EN (undefined: no forwarding, stall on any pending write to a source register)
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic            ValidD,
  input  logic            RegWriteD,
  input  logic            MemWriteD,
  input  logic            MemReadD,
  input  logic            OpBSrcD,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic [XLEN-1:0] ExtImmD,
  input  logic [2:0]      ALUFuncD,
  input  logic [4:0]      Rs1D,
  input  logic [4:0]      Rs2D,
  input  logic [4:0]      RdD,
  input  logic            StallE,
  input  logic            FlushE,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] ResultW,
  input  logic [4:0]      RdM,
  input  logic [4:0]      RdW,
  input  logic            RegWriteM,
  input  logic            RegWriteW,
  output logic [XLEN-1:0] OpA,
  output logic [XLEN-1:0] OpB,
  output logic [XLEN-1:0] ExtImmE,
  output logic [2:0]      ALUFuncE,
  output logic            OpBSrcE,
  output logic            ValidE,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            MemReadE,
  output logic [4:0]      RdE,
  output logic            StallD
);

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            mem_write;
    logic            mem_read;
    logic            op_b_src;
    logic [2:0]      alu_func;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] ext_imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } ex_t;

  ex_t  ex_q, ex_d;
  logic hazard_d;

  // x0 never matches: a zero destination is treated as "no destination"
  function automatic logic src_hit(input logic [4:0] r);
    return (r != 5'd0) && ((r == Rs1D) || (r == Rs2D));
  endfunction

`ifdef FORWARDING_EN
  assign hazard_d = ValidD && ex_q.valid && ex_q.mem_read && src_hit(ex_q.rd);

  always_comb begin
    OpA = ex_q.rd1;
    if (RegWriteM && (RdM != 5'd0) && (RdM == ex_q.rs1))
      OpA = ALUResultM;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == ex_q.rs1))
      OpA = ResultW;
  end

  always_comb begin
    OpB = ex_q.rd2;
    if (RegWriteM && (RdM != 5'd0) && (RdM == ex_q.rs2))
      OpB = ALUResultM;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == ex_q.rs2))
      OpB = ResultW;
  end
`else
  logic unused_fwd_data;

  assign hazard_d = ValidD && ((ex_q.valid && ex_q.reg_write && src_hit(ex_q.rd)) ||
                               (RegWriteM && src_hit(RdM)) ||
                               (RegWriteW && src_hit(RdW)));
  assign OpA = ex_q.rd1;
  assign OpB = ex_q.rd2;
  assign unused_fwd_data = ^{ALUResultM, ResultW};
`endif

  always_comb begin
    ex_d = ex_q;
    if (FlushE) begin
      ex_d = '0;
    end else if (StallE) begin
      ex_d = ex_q;
    end else if (hazard_d) begin
      ex_d = '0;
    end else begin
      ex_d.valid     = ValidD;
      ex_d.reg_write = RegWriteD;
      ex_d.mem_write = MemWriteD;
      ex_d.mem_read  = MemReadD;
      ex_d.op_b_src  = OpBSrcD;
      ex_d.alu_func  = ALUFuncD;
      ex_d.rd1       = RD1D;
      ex_d.rd2       = RD2D;
      ex_d.ext_imm   = ExtImmD;
      ex_d.rs1       = Rs1D;
      ex_d.rs2       = Rs2D;
      ex_d.rd        = RdD;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) ex_q <= '0;
    else       ex_q <= ex_d;
  end

  assign ValidE    = ex_q.valid;
  assign RegWriteE = ex_q.valid && ex_q.reg_write;
  assign MemWriteE = ex_q.valid && ex_q.mem_write;
  assign MemReadE  = ex_q.valid && ex_q.mem_read;
  assign OpBSrcE   = ex_q.op_b_src;
  assign ALUFuncE  = ex_q.alu_func;
  assign ExtImmE   = ex_q.ext_imm;
  assign RdE       = ex_q.rd;
  assign StallD    = hazard_d || StallE;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed and randomized check of id_ex_stage against a transaction-level model
module tb_id_ex_stage;
  localparam int XLEN = 32;

  logic            CLK = 1'b0;
  logic            reset;
  logic            ValidD, RegWriteD, MemWriteD, MemReadD, OpBSrcD;
  logic [XLEN-1:0] RD1D, RD2D, ExtImmD;
  logic [2:0]      ALUFuncD;
  logic [4:0]      Rs1D, Rs2D, RdD;
  logic            StallE, FlushE;
  logic [XLEN-1:0] ALUResultM, ResultW;
  logic [4:0]      RdM, RdW;
  logic            RegWriteM, RegWriteW;
  logic [XLEN-1:0] OpA, OpB, ExtImmE;
  logic [2:0]      ALUFuncE;
  logic            OpBSrcE, ValidE, RegWriteE, MemWriteE, MemReadE;
  logic [4:0]      RdE;
  logic            StallD;

  id_ex_stage #(.XLEN(XLEN)) dut (
    .CLK(CLK), .reset(reset),
    .ValidD(ValidD), .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .MemReadD(MemReadD), .OpBSrcD(OpBSrcD),
    .RD1D(RD1D), .RD2D(RD2D), .ExtImmD(ExtImmD), .ALUFuncD(ALUFuncD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .StallE(StallE), .FlushE(FlushE),
    .ALUResultM(ALUResultM), .ResultW(ResultW), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .OpA(OpA), .OpB(OpB), .ExtImmE(ExtImmE), .ALUFuncE(ALUFuncE), .OpBSrcE(OpBSrcE),
    .ValidE(ValidE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemReadE(MemReadE),
    .RdE(RdE), .StallD(StallD)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit        v, rw, mw, mr, obs;
    bit [2:0]  fn;
    bit [31:0] rd1, rd2, imm;
    bit [4:0]  rs1, rs2, rd;
  } ent_t;

  ent_t m;
  int   n_asserts = 0;
  int   n_fail    = 0;

  // instruction sitting in execute: nonzero destination that one of the decode sources reads
  function automatic bit reads_reg(input bit [4:0] r);
    return (r != 0) && (r == Rs1D || r == Rs2D);
  endfunction

  function automatic bit model_hazard();
`ifdef FORWARDING_EN
    return ValidD && m.v && m.mr && reads_reg(m.rd);
`else
    return ValidD && ((m.v && m.rw && reads_reg(m.rd)) ||
                      (RegWriteM && reads_reg(RdM)) || (RegWriteW && reads_reg(RdW)));
`endif
  endfunction

  function automatic bit [31:0] model_operand(input bit [4:0] rs, input bit [31:0] regv);
`ifdef FORWARDING_EN
    if (rs != 0 && RegWriteM && RdM == rs) return ALUResultM;
    if (rs != 0 && RegWriteW && RdW == rs) return ResultW;
`endif
    return regv;
  endfunction

  function automatic ent_t model_next();
    ent_t n;
    n = '{default: 0};
    if (reset || FlushE) return n;
    if (StallE) return m;
    if (model_hazard()) return n;
    n.v = ValidD; n.rw = RegWriteD; n.mw = MemWriteD; n.mr = MemReadD; n.obs = OpBSrcD;
    n.fn = ALUFuncD; n.rd1 = RD1D; n.rd2 = RD2D; n.imm = ExtImmD;
    n.rs1 = Rs1D; n.rs2 = Rs2D; n.rd = RdD;
    return n;
  endfunction

  task automatic chk(input string tag, input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, name, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk(tag, "ValidE",    ValidE,    m.v);
    chk(tag, "RegWriteE", RegWriteE, m.v & m.rw);
    chk(tag, "MemWriteE", MemWriteE, m.v & m.mw);
    chk(tag, "MemReadE",  MemReadE,  m.v & m.mr);
    chk(tag, "OpBSrcE",   OpBSrcE,   m.obs);
    chk(tag, "ALUFuncE",  ALUFuncE,  m.fn);
    chk(tag, "ExtImmE",   ExtImmE,   m.imm);
    chk(tag, "RdE",       RdE,       m.rd);
    chk(tag, "OpA",       OpA,       model_operand(m.rs1, m.rd1));
    chk(tag, "OpB",       OpB,       model_operand(m.rs2, m.rd2));
    chk(tag, "StallD",    StallD,    model_hazard() | StallE);
  endtask

  task automatic settle(input string tag);
    #1 check_all({tag, "_comb"});
  endtask

  task automatic edge_step(input string tag);
    ent_t n;
    n = model_next();
    @(posedge CLK);
    m = n;
    #1 check_all({tag, "_reg"});
    @(negedge CLK);
  endtask

  task automatic clear_inputs();
    reset = 0; ValidD = 0; RegWriteD = 0; MemWriteD = 0; MemReadD = 0; OpBSrcD = 0;
    RD1D = 0; RD2D = 0; ExtImmD = 0; ALUFuncD = 0; Rs1D = 0; Rs2D = 0; RdD = 0;
    StallE = 0; FlushE = 0; ALUResultM = 0; ResultW = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0;
  endtask

  task automatic rand_decode();
    ValidD = ($urandom_range(0, 3) != 0); RegWriteD = $urandom_range(0, 1);
    MemWriteD = $urandom_range(0, 1); MemReadD = $urandom_range(0, 1); OpBSrcD = $urandom_range(0, 1);
    RD1D = $urandom; RD2D = $urandom; ExtImmD = $urandom; ALUFuncD = $urandom_range(0, 7);
    Rs1D = $urandom_range(0, 5); Rs2D = $urandom_range(0, 5); RdD = $urandom_range(0, 5);
  endtask

  task automatic rand_later();
    ALUResultM = $urandom; ResultW = $urandom;
    RdM = $urandom_range(0, 5); RdW = $urandom_range(0, 5);
    RegWriteM = $urandom_range(0, 1); RegWriteW = $urandom_range(0, 1);
  endtask

  initial begin
    m = '{default: 0};
    clear_inputs();
    reset = 1;

    // reset state
    @(negedge CLK);
    settle("reset");
    chk("reset", "ValidE_d", ValidE, 0);
    chk("reset", "StallD_d", StallD, 0);
    edge_step("reset");
    reset = 0;

    // plain capture
    ValidD = 1; RD1D = 5; RD2D = 7; ALUFuncD = 3'b000; Rs1D = 1; Rs2D = 2; RdD = 8;
    settle("cap");
    edge_step("cap");
    chk("cap", "ValidE_d", ValidE, 1);
    chk("cap", "OpA_d", OpA, 5);
    chk("cap", "OpB_d", OpB, 7);
    chk("cap", "ALUFuncE_d", ALUFuncE, 0);

    // forwarding priority on OpA
    Rs1D = 3; RD1D = 32'h99; Rs2D = 0; RdD = 10;
    edge_step("fwd_cap");
    ValidD = 0; StallE = 1;
    RdM = 3; RegWriteM = 1; ALUResultM = 32'h11; RdW = 3; RegWriteW = 1; ResultW = 32'h22;
    settle("fwd_mw");
`ifdef FORWARDING_EN
    chk("fwd_mw", "OpA_d", OpA, 32'h11);
`else
    chk("fwd_mw", "OpA_d", OpA, 32'h99);
`endif
    edge_step("fwd_hold");
    RegWriteM = 0;
    settle("fwd_w");
`ifdef FORWARDING_EN
    chk("fwd_w", "OpA_d", OpA, 32'h22);
`else
    chk("fwd_w", "OpA_d", OpA, 32'h99);
`endif
    clear_inputs();

    // load-use bubble
    ValidD = 1; MemReadD = 1; RegWriteD = 1; RdD = 4;
    edge_step("ld_cap");
    MemReadD = 0; Rs1D = 1; Rs2D = 4; RdD = 9; RD2D = 32'h1234;
    settle("ld_use");
    chk("ld_use", "StallD_d", StallD, 1);
    edge_step("ld_bubble");
    chk("ld_bubble", "ValidE_d", ValidE, 0);
    chk("ld_bubble", "RegWriteE_d", RegWriteE, 0);
    settle("ld_retry");
    edge_step("ld_retry");
    chk("ld_retry", "ValidE_d", ValidE, 1);
    chk("ld_retry", "RdE_d", RdE, 9);
    clear_inputs();

    // register x0
    ValidD = 1; Rs1D = 0; RD1D = 0; MemReadD = 1; RdD = 0;
    edge_step("x0_cap");
    RdM = 0; RegWriteM = 1; ALUResultM = 32'hFF; MemReadD = 0;
    settle("x0");
    chk("x0", "OpA_d", OpA, 0);
    chk("x0", "StallD_d", StallD, 0);
    clear_inputs();

    // flush beats stall, then a 3-cycle stall holds everything
    ValidD = 1; RdD = 2;
    edge_step("fs_cap");
    FlushE = 1; StallE = 1;
    edge_step("fs_flush");
    chk("fs_flush", "ValidE_d", ValidE, 0);
    FlushE = 0; StallE = 0; ValidD = 1; RdD = 5; RD1D = 32'hABCD; ExtImmD = 32'h77;
    edge_step("st_cap");
    for (int i = 0; i < 3; i++) begin
      rand_decode();
      StallE = 1;
      settle("stall");
      chk("stall", "StallD_d", StallD, 1);
      edge_step("stall");
      chk("stall", "RdE_d", RdE, 5);
    end
    clear_inputs();

    // asynchronous reset between edges
    ValidD = 1; RdD = 3;
    edge_step("ar_cap");
    #2 reset = 1;
    m = '{default: 0};
    #1 chk("ar", "ValidE_d", ValidE, 0);
    @(negedge CLK);
    reset = 0; ValidD = 1; RdW = 6; RegWriteW = 1; Rs1D = 6; RdD = 1;
    settle("ar_w");
`ifndef FORWARDING_EN
    chk("ar_w", "StallD_d", StallD, 1);
`endif
    edge_step("ar_post");
    clear_inputs();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_decode();
      rand_later();
      FlushE = ($urandom_range(0, 7) == 0);
      StallE = ($urandom_range(0, 3) == 0);
      reset  = ($urandom_range(0, 15) == 0);
      if (reset) m = '{default: 0};
      settle("rnd");
      edge_step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
